// File: rtl/task_out_packetizer_if.sv
// -----------------------------------------------------------------------------
// task_out_packetizer_if
// Groups the task-core input stream, the task-manager output stream and the
// packetizer status flags into one bundle.
//   slave  : packetizer side (drives o_*, samples i_*)
//   master : task core / task manager side (drives i_*, samples o_*)
// Signals:
//   i_data, i_data_valid, i_input_last : input word stream
//   o_in_ready                         : input backpressure
//   i_tmanager_ready                   : manager accepts current beat
//   o_tanswer_ready, o_tdata,
//   o_tanswer_data_last                : output beat stream
//   o_packet_size_in_bytes             : byte count of packet in flight
//   o_busy, o_full, o_overflow         : status
// -----------------------------------------------------------------------------
interface task_out_packetizer_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SIZE_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_data_valid;
   logic                  i_input_last;
   logic                  o_in_ready;
   logic                  i_tmanager_ready;
   logic                  o_tanswer_ready;
   logic [DATA_WIDTH-1:0] o_tdata;
   logic                  o_tanswer_data_last;
   logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes;
   logic                  o_busy;
   logic                  o_full;
   logic                  o_overflow;

   modport slave (
      input  i_data, i_data_valid, i_input_last, i_tmanager_ready,
      output o_in_ready, o_tanswer_ready, o_tdata, o_tanswer_data_last,
             o_packet_size_in_bytes, o_busy, o_full, o_overflow
   );

   modport master (
      output i_data, i_data_valid, i_input_last, i_tmanager_ready,
      input  o_in_ready, o_tanswer_ready, o_tdata, o_tanswer_data_last,
             o_packet_size_in_bytes, o_busy, o_full, o_overflow
   );
endinterface

// File: rtl/task_out_packetizer.sv
// -----------------------------------------------------------------------------
// task_out_packetizer
// Collects task-core words into a FIFO, closes a packet on an input last flag
// or on the MAX_PKT_WORDS limit, then streams it to the task manager with a
// valid/ready handshake, a last flag and the packet byte count.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : task_out_packetizer_if.slave (input stream, output stream, status)
// Optional feature macro:
//   PKT_TIMEOUT_EN : close a non-empty packet after TIMEOUT_CYCLES idle cycles
// -----------------------------------------------------------------------------
module task_out_packetizer #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned DEPTH          = 64,
   parameter int unsigned MAX_PKT_WORDS  = 64,
   parameter int unsigned SIZE_WIDTH     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   task_out_packetizer_if.slave  bus
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned BYTES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {s_LOAD, s_FRAME, s_SEND, s_DONE} state_t;

   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] head_q;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_addr;
   logic [CW-1:0]         count_q, wr_cnt_q, rd_cnt_q, pkt_words_q;
   logic [SIZE_WIDTH-1:0] size_q;
   logic                  busy_q, overflow_q;

   logic full, in_ready, wr_en, out_valid, rd_en, beat_last, limit_hit, close_in;
   logic timeout_hit;

   assign full      = (count_q == CW'(DEPTH));
   assign in_ready  = (state_q == s_LOAD) && !full;
   assign wr_en     = bus.i_data_valid && in_ready;
   assign out_valid = (state_q == s_SEND) && (count_q != '0);
   assign rd_en     = out_valid && bus.i_tmanager_ready;
   assign beat_last = out_valid && (rd_cnt_q == (pkt_words_q - CW'(1)));
   assign limit_hit = ((wr_cnt_q + CW'(1)) == CW'(MAX_PKT_WORDS));
   // Last flag and word limit on the same word collapse into one close.
   assign close_in  = wr_en && (bus.i_input_last || limit_hit);

`ifdef PKT_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_q, idle_inc;

   assign idle_inc    = idle_q + TW'(1);
   // Only a partially filled packet can time out.
   assign timeout_hit = (state_q == s_LOAD) && !wr_en && (wr_cnt_q != '0) &&
                        (idle_inc == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idle_q <= '0;
      end else if ((state_q != s_LOAD) || wr_en) begin
         idle_q <= '0;
      end else if (wr_cnt_q != '0) begin
         idle_q <= idle_inc;
      end
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         s_LOAD:  if (close_in || timeout_hit) state_d = s_FRAME;
         s_FRAME: state_d = s_SEND;
         s_SEND:  if (rd_en && beat_last) state_d = s_DONE;
         s_DONE:  state_d = s_LOAD;
         default: state_d = s_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= s_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Storage and head register: the read address looks one word ahead on a
   // transfer so the head register already holds the next beat (fall-through).
   assign rd_addr = rd_en ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.i_data;
      end
      if ((state_q == s_FRAME) || rd_en) begin
         head_q <= mem[rd_addr];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Packet framing counters and status
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         pkt_words_q <= '0;
         size_q      <= '0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (wr_en) wr_cnt_q <= wr_cnt_q + CW'(1);
         if (rd_en) rd_cnt_q <= rd_cnt_q + CW'(1);
         if (state_q == s_FRAME) begin
            pkt_words_q <= wr_cnt_q;
            size_q      <= SIZE_WIDTH'(32'(wr_cnt_q) * BYTES);
            busy_q      <= 1'b1;
         end
         if (state_q == s_DONE) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            size_q   <= '0;
            busy_q   <= 1'b0;
         end
         if (bus.i_data_valid && !in_ready) overflow_q <= 1'b1;
      end
   end

   assign bus.o_in_ready             = in_ready;
   assign bus.o_tanswer_ready        = out_valid;
   assign bus.o_tdata                = out_valid ? head_q : '0;
   assign bus.o_tanswer_data_last    = beat_last;
   assign bus.o_packet_size_in_bytes = size_q;
   assign bus.o_busy                 = busy_q;
   assign bus.o_full                 = full;
   assign bus.o_overflow             = overflow_q;

endmodule

// File: tb/tb_task_out_packetizer.sv
// -----------------------------------------------------------------------------
// tb_task_out_packetizer
// Directed bench: a packet model pushes expected beats/sizes into queues as
// words are accepted; the per-cycle monitor pops and compares them as the
// DUT emits beats. Build with +define+PKT_TIMEOUT_EN to exercise the timeout.
// -----------------------------------------------------------------------------
module tb_task_out_packetizer;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned MAXW  = 8;
   localparam int unsigned SW    = 12;
   localparam int unsigned TO    = 16;
   localparam int unsigned BYTES = DW / 8;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;

   always #5 i_clk = ~i_clk;

   task_out_packetizer_if #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

   task_out_packetizer #(
      .DATA_WIDTH     (DW),
      .DEPTH          (DEPTH),
      .MAX_PKT_WORDS  (MAXW),
      .SIZE_WIDTH     (SW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus.slave)
   );

   logic [DW-1:0] exp_data[$];
   bit            exp_last[$];
   logic [SW-1:0] exp_size[$];
   logic [DW-1:0] pend[$];
   bit            rdy_pat[$];
   int            model_cnt = 0;
   int            frame_chk = 0;
   int            post_last = 0;
   bit            exp_full_v = 1'b0;
   int            n_asserts = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_in_ready"}, 32'(bus.o_in_ready), 1);
      chk({pfx, "_out_valid"}, 32'(bus.o_tanswer_ready), 0);
      chk({pfx, "_last"}, 32'(bus.o_tanswer_data_last), 0);
      chk({pfx, "_busy"}, 32'(bus.o_busy), 0);
      chk({pfx, "_full"}, 32'(bus.o_full), 0);
      chk({pfx, "_overflow"}, 32'(bus.o_overflow), 0);
      chk({pfx, "_size"}, 32'(bus.o_packet_size_in_bytes), 0);
      chk({pfx, "_tdata"}, 32'(bus.o_tdata), 0);
   endtask

   // Model: move pending words into the expected-beat scoreboard on a close.
   task automatic close_pkt();
      for (int i = 0; i < pend.size(); i++) begin
         exp_data.push_back(pend[i]);
         exp_last.push_back(i == pend.size() - 1);
      end
      exp_size.push_back(SW'(model_cnt * BYTES));
      exp_full_v = (model_cnt == DEPTH);
      pend.delete();
      model_cnt = 0;
      frame_chk = 1;
   endtask

   // One clock: sample at negedge, then advance to just after the posedge.
   task automatic cycle();
      @(negedge i_clk);
      if (frame_chk == 2) begin
         chk("first_beat_valid", 32'(bus.o_tanswer_ready), 1);
         frame_chk = 0;
      end else if (frame_chk == 1) begin
         chk("frame_in_ready", 32'(bus.o_in_ready), 0);
         chk("frame_out_valid", 32'(bus.o_tanswer_ready), 0);
         chk("frame_full", 32'(bus.o_full), 32'(exp_full_v));
         frame_chk = 2;
      end
      if (post_last == 2) begin
         chk("load_busy", 32'(bus.o_busy), 0);
         chk("load_in_ready", 32'(bus.o_in_ready), 1);
         post_last = 0;
      end else if (post_last == 1) begin
         chk("done_busy", 32'(bus.o_busy), 1);
         chk("done_in_ready", 32'(bus.o_in_ready), 0);
         chk("done_out_valid", 32'(bus.o_tanswer_ready), 0);
         post_last = 2;
      end
      if (bus.o_tanswer_ready) begin
         n_asserts++;
         assert (exp_data.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_beat: observed data %0h expected no beat", bus.o_tdata);
         end
         if (exp_data.size() != 0) begin
            chk("beat_data", 32'(bus.o_tdata), 32'(exp_data[0]));
            chk("beat_last", 32'(bus.o_tanswer_data_last), 32'(exp_last[0]));
            chk("beat_size", 32'(bus.o_packet_size_in_bytes), 32'(exp_size[0]));
            chk("beat_busy", 32'(bus.o_busy), 1);
            if (bus.i_tmanager_ready) begin
               void'(exp_data.pop_front());
               if (exp_last.pop_front()) begin
                  void'(exp_size.pop_front());
                  post_last = 1;
               end
            end
         end
      end
      @(posedge i_clk);
      #1;
      bus.i_tmanager_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
   endtask

   task automatic send_word(input logic [DW-1:0] d, input bit last);
      int guard = 0;
      while (!bus.o_in_ready && guard < 100) begin
         cycle();
         guard++;
      end
      chk("in_ready_wait", 32'(bus.o_in_ready), 1);
      bus.i_data       = d;
      bus.i_input_last = last;
      bus.i_data_valid = 1'b1;
      cycle();
      bus.i_data_valid = 1'b0;
      bus.i_input_last = 1'b0;
      pend.push_back(d);
      model_cnt++;
      if (last || model_cnt == MAXW) close_pkt();
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_data.size() != 0 || bus.o_busy) && guard < 200) begin
         cycle();
         guard++;
      end
      n_asserts++;
      assert (guard < 200) else begin
         n_fail++;
         $error("FAIL drain_timeout: observed %0d beats pending expected 0", exp_data.size());
      end
   endtask

   initial begin
      bus.i_data           = '0;
      bus.i_data_valid     = 1'b0;
      bus.i_input_last     = 1'b0;
      bus.i_tmanager_ready = 1'b1;
      #12;
      chk_reset_vals("rst");
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Basic 5-word packet closed by last
      for (int i = 0; i < 5; i++) send_word(DW'(16'h11 + i), i == 4);
      wait_idle();

      // Word limit closes at 8 (FIFO full); words 9..11 form the next packet,
      // which is drained under a stalling manager.
      for (int i = 0; i < 8; i++) send_word(DW'(16'h20 + i), 1'b0);
      send_word(16'h0029, 1'b0);
      send_word(16'h002A, 1'b0);
      send_word(16'h002B, 1'b1);
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      wait_idle();

      // Idle input with 0 words never closes
      for (int i = 0; i < 40; i++) begin
         chk("idle0_busy", 32'(bus.o_busy), 0);
         cycle();
      end

`ifdef PKT_TIMEOUT_EN
      for (int i = 0; i < 3; i++) send_word(DW'(16'h40 + i), 1'b0);
      for (int i = 0; i < TO; i++) begin
         chk("timeout_wait_in_ready", 32'(bus.o_in_ready), 1);
         cycle();
      end
      close_pkt();
      wait_idle();
`else
      for (int i = 0; i < 3; i++) send_word(DW'(16'h40 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         chk("no_timeout_in_ready", 32'(bus.o_in_ready), 1);
         cycle();
      end
      send_word(16'h0043, 1'b1);
      wait_idle();
`endif

      // Overflow: write while in s_FRAME is dropped and sets the sticky flag
      send_word(16'h0077, 1'b1);
      bus.i_data       = 16'hDEAD;
      bus.i_input_last = 1'b1;
      bus.i_data_valid = 1'b1;
      cycle();
      bus.i_data_valid = 1'b0;
      bus.i_input_last = 1'b0;
      chk("overflow_set", 32'(bus.o_overflow), 1);
      wait_idle();
      send_word(16'h0088, 1'b1);
      wait_idle();
      chk("overflow_sticky", 32'(bus.o_overflow), 1);

      // Async reset after 2 of 8 beats
      for (int i = 0; i < 8; i++) send_word(DW'(16'h100 + i), i == 7);
      begin
         int guard = 0;
         while (exp_data.size() > 6 && guard < 100) begin
            cycle();
            guard++;
         end
         chk("midsend_two_beats", 32'(exp_data.size()), 6);
      end
      i_rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      exp_data.delete();
      exp_last.delete();
      exp_size.delete();
      pend.delete();
      rdy_pat.delete();
      model_cnt = 0;
      frame_chk = 0;
      post_last = 0;
      bus.i_tmanager_ready = 1'b1;
      #2;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      send_word(16'h00A5, 1'b1);
      wait_idle();
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/task_out_packetizer.md
Name: task_out_packetizer

Overview:
Parametrised successor to the task output stage. It collects words produced by a task core into an internal FIFO and frames them into one packet. It then streams the packet to the task manager with a valid/ready handshake, a last flag and a byte count. Unlike the fixed-size stage, it closes a packet on either an input last flag or a programmable word limit, reports the actual packet size, and applies input backpressure.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
DEPTH, 64, FIFO depth in words; power of two, >= 2.
MAX_PKT_WORDS, 64, word limit that closes a packet; 1..DEPTH.
SIZE_WIDTH, 12, width of the byte-count output.
TIMEOUT_CYCLES, 256, idle cycles before a forced close; used only with PKT_TIMEOUT_EN.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  DATA_WIDTH  task result word
i_data_valid  in  1  i_data valid this cycle
i_input_last  in  1  final word of packet; qualified by i_data_valid
o_in_ready  out  1  word accepted when i_data_valid && o_in_ready
i_tmanager_ready  in  1  manager accepts the current beat
o_tanswer_ready  out  1  o_tdata valid (output valid)
o_tdata  out  DATA_WIDTH  packet word
o_tanswer_data_last  out  1  current beat is the final word
o_packet_size_in_bytes  out  SIZE_WIDTH  packet byte count; valid while o_busy
o_busy  out  1  packet framed or sending
o_full  out  1  FIFO holds DEPTH words
o_overflow  out  1  sticky: write attempted while o_in_ready low

Behaviour:
- Reset (async assert, sync release): state s_LOAD, FIFO empty, counters 0. Outputs: o_in_ready=1, o_tanswer_ready=0, o_tanswer_data_last=0, o_busy=0, o_full=0, o_overflow=0, o_packet_size_in_bytes=0, o_tdata=0. Asserting reset mid-packet flushes everything.
- FIFO: inferred RAM with a first-word-fall-through output register, so o_tdata is valid in the same cycle as o_tanswer_ready. It has a write pointer, a read pointer and a log2(DEPTH)+1-bit count. Pointers wrap modulo DEPTH.
- s_LOAD:
  - o_in_ready = !o_full.
  - Each accepted word increments wr_cnt.
  - Go to s_FRAME on the accepting cycle if i_input_last=1 or wr_cnt+1 == MAX_PKT_WORDS.
  - i_input_last without i_data_valid is ignored.
- s_FRAME (one cycle):
  - o_in_ready=0.
  - Latch pkt_words = wr_cnt.
  - o_packet_size_in_bytes <= wr_cnt * (DATA_WIDTH/8), truncated to SIZE_WIDTH.
  - o_busy <= 1. Go to s_SEND.
- s_SEND:
  - o_in_ready=0, o_tanswer_ready=1 while the FIFO is non-empty.
  - A beat transfers when o_tanswer_ready && i_tmanager_ready; rd_cnt increments.
  - o_tanswer_data_last = o_tanswer_ready && (rd_cnt == pkt_words-1).
  - o_tdata and o_tanswer_data_last hold stable while i_tmanager_ready=0.
  - Next state on the last-beat transfer is s_DONE.
- s_DONE (one cycle):
  - o_busy <= 0, o_packet_size_in_bytes <= 0, wr_cnt and rd_cnt cleared.
  - Go to s_LOAD; o_in_ready rises on the following cycle.
- Single packet in flight: no words are accepted from s_FRAME through s_DONE.
- Latency: first output beat is valid 2 cycles after the closing word is accepted. Throughput is 1 beat per cycle with continuous i_tmanager_ready.
- o_full, when wr_cnt reaches DEPTH:
  - only reachable if MAX_PKT_WORDS == DEPTH, which forces a close anyway;
  - a write on a full FIFO is dropped and sets o_overflow;
  - o_overflow clears only on reset.
- Simultaneous i_input_last with the MAX_PKT_WORDS limit: a single close; no empty packet is produced.

Optional Feature:
PKT_TIMEOUT_EN
- Defined: in s_LOAD with wr_cnt >= 1, an idle counter counts cycles with no accepted word. It is reset by each accepted word. On reaching TIMEOUT_CYCLES it forces s_FRAME with the current wr_cnt. It never fires with wr_cnt == 0.
- Undefined: no idle counter; packets close only on i_input_last or MAX_PKT_WORDS.

Test Plan:
- Reset then 5 words 0x11..0x15, last on 0x15, manager ready=1 -> o_packet_size_in_bytes=5; beats 0x11..0x15 on consecutive cycles; last only on 0x15; o_busy low 1 cycle after.
- MAX_PKT_WORDS=4, 6 words with no last -> packet of 4 (size=4); o_in_ready low from s_FRAME to s_DONE; words 5 and 6 start the next packet after the source retries.
- Output stall: 3-word packet, i_tmanager_ready toggling 1,0,0,1,0,1 -> o_tdata/last stable during 0 cycles; exactly 3 transfers; last on the third.
- Overflow: force a write while o_in_ready=0 -> word dropped; o_overflow=1 and stays set until i_rst_n asserted.
- Async reset mid-send after 2 of 8 beats -> all outputs at reset values immediately; next packet of 1 word (0xA5, last) yields size=1, a single beat 0xA5 with last=1.
- With PKT_TIMEOUT_EN, TIMEOUT_CYCLES=16: 3 words then idle -> close after 16 idle cycles; size=3; an idle line with 0 words never closes.
